forward_scoreboard: RTL and testbench

- Parametrised successor to the pipeline's combinational EX/MEM–MEM/WB forwarding logic.
- Keeps its own shift-register record of in-flight producers, DEPTH stages deep.
- For each of NSRC source operands of the instruction at the issue point (ID/EX), selects the nearest valid producer.
- Detects load-use hazards for any load latency and raises stall; counts stall cycles.
- Sits beside the hazard unit and drives the EX-stage operand muxes.

---
 rtl/forward_scoreboard.sv | 99 +++++++++
 tb/tb_forward_scoreboard.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/forward_scoreboard.sv
// Operand forwarding scoreboard: tracks DEPTH in-flight producers after issue,
// picks the nearest forwarding source per operand and flags load-use stalls.
module forward_scoreboard #(
    parameter int REG_W    = 5,
    parameter int DEPTH    = 3,
    parameter int NSRC     = 2,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = $clog2(DEPTH + 1),
    parameter int CNT_W    = 32
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    id_valid,
    input  logic [NSRC*REG_W-1:0]   id_src,
    input  logic [REG_W-1:0]        id_rd,
    input  logic                    id_regwrite,
    input  logic                    id_memread,
    input  logic                    advance,
    input  logic                    flush,
    output logic [NSRC*SEL_W-1:0]   fwd_sel,
    output logic                    stall,
    output logic [CNT_W-1:0]        stall_cnt
);

    // Index 0 holds stage 1 (EX/MEM), index DEPTH-1 holds the oldest producer.
    logic [DEPTH-1:0] ent_valid;
    logic [DEPTH-1:0] ent_regwrite;
    logic [DEPTH-1:0] ent_memread;
    logic [REG_W-1:0] ent_rd [DEPTH];

    logic [SEL_W-1:0] near_sel [NSRC];
    logic             near_ld  [NSRC];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Scan oldest to newest so the nearest match is the last one written.
    always_comb begin
        for (int i = 0; i < NSRC; i++) begin
            near_sel[i] = '0;
            near_ld[i]  = 1'b0;
            if (id_valid && (id_src[i*REG_W +: REG_W] != '0)) begin
                for (int k = DEPTH - 1; k >= 0; k--) begin
                    if (ent_valid[k] && ent_regwrite[k] && (ent_rd[k] != '0) &&
                        (ent_rd[k] == id_src[i*REG_W +: REG_W])) begin
                        near_sel[i] = SEL_W'(k + 1);
                        near_ld[i]  = ent_memread[k] && ((k + 1) < LOAD_LAT);
                    end
                end
            end
        end
    end

    // A load too young to forward blocks the operand; older matches are stale.
    always_comb begin
        fwd_sel = '0;
        stall   = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            fwd_sel[i*SEL_W +: SEL_W] = near_ld[i] ? '0 : near_sel[i];
            stall                     = stall | near_ld[i];
        end
    end

    // ---- producer stage boundary: control ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            ent_valid <= '0;
            stall_cnt <= '0;
        end else begin
            if (flush) begin
                ent_valid <= '0;
            end else if (advance) begin
                for (int k = 1; k < DEPTH; k++) begin
                    ent_valid[k] <= ent_valid[k-1];
                end
                ent_valid[0] <= id_valid && !stall;
            end
            if (advance && stall && !flush) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end

    // ---- producer stage boundary: payload, qualified by ent_valid ----
    always_ff @(posedge CLK) begin
        if (advance) begin
            for (int k = 1; k < DEPTH; k++) begin
                ent_rd[k]       <= ent_rd[k-1];
                ent_regwrite[k] <= ent_regwrite[k-1];
                ent_memread[k]  <= ent_memread[k-1];
            end
            ent_rd[0]       <= id_rd;
            ent_regwrite[0] <= id_regwrite;
            ent_memread[0]  <= id_memread;
        end
    end

endmodule

// File: tb/tb_forward_scoreboard.sv
// Scoreboard bench for forward_scoreboard: a behavioural producer-list model
// queues expected outputs for each driven cycle; the sampler pops and compares.
module tb_forward_scoreboard;

    localparam int REG_W    = 5;
    localparam int DEPTH    = 3;
    localparam int NSRC     = 2;
    localparam int LOAD_LAT = 2;
    localparam int SEL_W    = $clog2(DEPTH + 1);
    localparam int CNT_W    = 32;

    logic                  CLK = 1'b0;
    logic                  RST;
    logic                  id_valid;
    logic [NSRC*REG_W-1:0] id_src;
    logic [REG_W-1:0]      id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  advance;
    logic                  flush;
    logic [NSRC*SEL_W-1:0] fwd_sel;
    logic                  stall;
    logic [CNT_W-1:0]      stall_cnt;

    forward_scoreboard #(
        .REG_W(REG_W), .DEPTH(DEPTH), .NSRC(NSRC), .LOAD_LAT(LOAD_LAT),
        .SEL_W(SEL_W), .CNT_W(CNT_W)
    ) dut (
        .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_src(id_src),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
        .advance(advance), .flush(flush), .fwd_sel(fwd_sel), .stall(stall),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          sel0;
        int          sel1;
        int          st;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Reference model: producer list, element 0 is the youngest.
    bit          m_v  [DEPTH];
    bit          m_rw [DEPTH];
    bit          m_mr [DEPTH];
    logic [4:0]  m_rd [DEPTH];
    logic [31:0] m_cnt = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, want, $time);
        end
    endtask

    function automatic void model_op(input bit v, input logic [4:0] src,
                                     output int sel, output int ld);
        sel = 0;
        ld  = 0;
        if (v && src != 5'd0) begin
            for (int k = 0; k < DEPTH; k++) begin
                if (m_v[k] && m_rw[k] && m_rd[k] == src) begin
                    if (m_mr[k] && (k + 1) < LOAD_LAT) ld = 1;
                    else sel = k + 1;
                    break;
                end
            end
        end
    endfunction

    task automatic cycle(input bit do_chk, input bit rst, input bit v,
                         input logic [4:0] s0, input logic [4:0] s1,
                         input logic [4:0] rd, input bit rw, input bit mr,
                         input bit adv, input bit fl);
        exp_t e;
        exp_t got;
        int   ld0, ld1;
        RST = rst; id_valid = v; id_src = {s1, s0}; id_rd = rd;
        id_regwrite = rw; id_memread = mr; advance = adv; flush = fl;
        model_op(v, s0, e.sel0, ld0);
        model_op(v, s1, e.sel1, ld1);
        e.st  = (ld0 != 0 || ld1 != 0) ? 1 : 0;
        e.cnt = m_cnt;
        if (do_chk) exp_q.push_back(e);
        @(negedge CLK);
        if (do_chk) begin
            if (exp_q.size() == 0) begin
                chk("queue_empty", 32'd1, 32'd0);
            end else begin
                got = exp_q.pop_front();
                chk("fwd_sel0", 32'(fwd_sel[SEL_W-1:0]), 32'(got.sel0));
                chk("fwd_sel1", 32'(fwd_sel[2*SEL_W-1:SEL_W]), 32'(got.sel1));
                chk("stall", 32'(stall), 32'(got.st));
                chk("stall_cnt", stall_cnt, got.cnt);
            end
        end
        @(posedge CLK);
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) m_v[k] = 0;
            m_cnt = '0;
        end else begin
            if (fl) begin
                for (int k = 0; k < DEPTH; k++) m_v[k] = 0;
            end else if (adv) begin
                for (int k = DEPTH - 1; k > 0; k--) begin
                    m_v[k] = m_v[k-1]; m_rw[k] = m_rw[k-1];
                    m_mr[k] = m_mr[k-1]; m_rd[k] = m_rd[k-1];
                end
                m_v[0] = v && (e.st == 0); m_rw[0] = rw; m_mr[0] = mr; m_rd[0] = rd;
            end
            if (adv && e.st != 0 && !fl && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
        end
        #1;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            m_v[k] = 0; m_rw[k] = 0; m_mr[k] = 0; m_rd[k] = '0;
        end
        @(posedge CLK); #1;
        //     chk rst v  s0 s1 rd rw mr adv fl
        cycle(0, 1, 0, 0, 0, 0, 0, 0, 1, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 1, 0);   // reset state
        // add r3, then consumers at distance 1 and 2
        cycle(1, 0, 1, 1, 2, 3, 1, 0, 1, 0);
        cycle(1, 0, 1, 3, 4, 6, 1, 0, 1, 0);
        cycle(1, 0, 1, 3, 0, 0, 0, 0, 1, 0);
        // two writers of r5: nearest wins
        cycle(1, 0, 1, 0, 0, 5, 1, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 5, 1, 0, 1, 0);
        cycle(1, 0, 1, 6, 5, 0, 0, 0, 1, 0);
        // r0 destination and regwrite=0 never forward
        cycle(1, 0, 1, 0, 0, 0, 1, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 9, 0, 0, 1, 0);
        cycle(1, 0, 1, 0, 9, 0, 0, 0, 1, 0);
        // load-use: one stall cycle, then forward from stage 2
        cycle(1, 0, 1, 1, 1, 7, 1, 1, 1, 0);
        cycle(1, 0, 1, 7, 7, 2, 1, 0, 1, 0);
        cycle(1, 0, 1, 7, 7, 2, 1, 0, 1, 0);
        // load-use while the pipeline is frozen
        cycle(1, 0, 1, 0, 0, 8, 1, 1, 1, 0);
        cycle(1, 0, 1, 8, 0, 4, 1, 0, 0, 0);
        cycle(1, 0, 1, 8, 0, 4, 1, 0, 0, 0);
        cycle(1, 0, 1, 8, 0, 4, 1, 0, 0, 0);
        cycle(1, 0, 1, 8, 0, 4, 1, 0, 1, 0);
        cycle(1, 0, 1, 8, 0, 4, 1, 0, 1, 0);
        // flush with three live producers
        cycle(1, 0, 1, 0, 0, 10, 1, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 11, 1, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 12, 1, 0, 1, 0);
        cycle(1, 0, 1, 10, 11, 13, 1, 0, 1, 1);
        cycle(1, 0, 1, 10, 12, 0, 0, 0, 1, 0);
        // reset during a stall
        cycle(1, 0, 1, 0, 0, 13, 1, 1, 1, 0);
        cycle(1, 0, 1, 13, 0, 1, 1, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 13, 1, 1, 1, 0);
        cycle(1, 1, 1, 13, 0, 1, 1, 0, 1, 0);
        cycle(1, 0, 1, 13, 0, 1, 1, 0, 1, 0);
        // randomized traffic on a small register set to provoke overlaps
        for (int n = 0; n < 400; n++) begin
            cycle(1, ($urandom_range(0, 79) == 0), ($urandom_range(0, 5) != 0),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) != 0),
                  ($urandom_range(0, 19) == 0));
        end
        if (exp_q.size() != 0) chk("queue_drain", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
